fifo_width_down: RTL



---
 rtl/fifo_width_down_pkg.sv | 29 ++
 rtl/fifo_width_down_sel.sv | 47 ++++
 rtl/fifo_width_down.sv | 124 ++++++++++++
 3 files changed

// File: rtl/fifo_width_down_pkg.sv
// Shared definitions for the fifo_width_down drain stage: the control state
// encoding, the beat counter width helper and the parameter legality check.

package fifo_width_down_pkg;

    // Control states: no word held, or a word being emitted beat by beat.
    typedef enum logic {
        EMPTY  = 1'b0,
        STREAM = 1'b1
    } state_t;

    // Beat counter width; a 1-bit counter is kept even for degenerate ratios
    // so the counter vector never collapses to zero width.
    function automatic int beat_cnt_w(input int ratio);
        int w;
        w = $clog2(ratio);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// Elaboration-time guard: the wide word must split evenly into at least two
// beats. Expands to a generate-if, so it is placed in a module body.
`ifndef FIFO_WIDTH_DOWN_PARAM_CHECK
`define FIFO_WIDTH_DOWN_PARAM_CHECK(iw, r) \
    if ((((iw) % (r)) != 0) || ((r) < 2)) begin : g_bad_params \
        $error("fifo_width_down: IN_WIDTH must be a multiple of RATIO and RATIO must be >= 2"); \
    end
`endif

// File: rtl/fifo_width_down_sel.sv
// Registered slice mux: picks beat IDX of WORD (LSB-first or MSB-first) and
// registers it so the narrow output data comes straight from a flop.
// WORD/IDX are the next-cycle hold word and beat index from the control logic,
// so the registered slice always matches the beat being presented.

module fifo_width_down_sel
    import fifo_width_down_pkg::*;
#(
    parameter int IN_WIDTH  = 32,
    parameter int RATIO     = 4,
    parameter int MSB_FIRST = 0,
    parameter int BCW       = beat_cnt_w(RATIO)
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [IN_WIDTH-1:0]       WORD,
    input  logic [BCW-1:0]            IDX,
    output logic [IN_WIDTH/RATIO-1:0] OUT_DATA
);

    localparam int OUT_WIDTH = IN_WIDTH / RATIO;

    int                   slice_idx;
    logic [OUT_WIDTH-1:0] slice_data;

    // Map the beat index to a slice number and extract that slice.
    always_comb begin
        slice_idx  = 0;
        slice_data = '0;
        if (MSB_FIRST != 0) begin
            slice_idx = RATIO - 1 - int'(IDX);
        end else begin
            slice_idx = int'(IDX);
        end
        slice_data = WORD[slice_idx*OUT_WIDTH +: OUT_WIDTH];
    end

    // Register the selected slice; cleared by reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            OUT_DATA <= '0;
        end else begin
            OUT_DATA <= slice_data;
        end
    end

endmodule

// File: rtl/fifo_width_down.sv
// Width-down drain stage: pops one IN_WIDTH word from a FIFO (EMPTY_N/DEQ/D_OUT)
// and emits it as RATIO narrow beats on a valid/ready stream with a last-beat
// marker. Reloads on the last accepted beat, so consecutive words stream with
// no bubbles.
//
// Handshake: a beat transfers on a cycle where OUT_VALID && OUT_READY at the
// rising clock edge. Once OUT_VALID is high it stays high, and OUT_DATA and
// OUT_LAST stay stable, until the beat transfers; only CLR or RST withdraw it.
// OUT_VALID never depends combinationally on OUT_READY.

module fifo_width_down
    import fifo_width_down_pkg::*;
#(
    parameter int IN_WIDTH  = 32,
    parameter int RATIO     = 4,
    parameter int MSB_FIRST = 0
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      CLR,
    input  logic [IN_WIDTH-1:0]       FIFO_D_OUT,
    input  logic                      FIFO_EMPTY_N,
    output logic                      FIFO_DEQ,
    output logic [IN_WIDTH/RATIO-1:0] OUT_DATA,
    output logic                      OUT_VALID,
    input  logic                      OUT_READY,
    output logic                      OUT_LAST,
    output logic                      BUSY,
    output logic                      DBG_STATE
);

    localparam int             OUT_WIDTH = IN_WIDTH / RATIO;
    localparam int             BCW       = beat_cnt_w(RATIO);
    localparam logic [BCW-1:0] LAST_CNT  = BCW'(RATIO - 1);
    localparam logic [BCW-1:0] CNT_ONE   = BCW'(1);

    `FIFO_WIDTH_DOWN_PARAM_CHECK(IN_WIDTH, RATIO)

    state_t                state_q;
    state_t                state_d;
    logic [BCW-1:0]        beat_cnt_q;
    logic [BCW-1:0]        beat_cnt_d;
    logic [IN_WIDTH-1:0]   hold_reg_q;
    logic [IN_WIDTH-1:0]   hold_reg_d;
    logic                  run_q;
    logic                  beat_xfer;
    logic                  last_xfer;
    logic                  deq;

    // Stream-side status comes straight from flops.
    assign OUT_VALID = (state_q == STREAM);
    assign OUT_LAST  = (state_q == STREAM) && (beat_cnt_q == LAST_CNT);
    assign BUSY      = OUT_VALID;
    assign DBG_STATE = (state_q == STREAM);

    assign beat_xfer = OUT_VALID && OUT_READY;
    assign last_xfer = beat_xfer && (beat_cnt_q == LAST_CNT);

    // Pop when idle or when the final beat leaves; CLR always blocks the pop.
    // run_q holds off the first pop until one full cycle out of reset, which
    // also keeps the pop low throughout reset without a path from RST.
    assign deq      = run_q && FIFO_EMPTY_N && !CLR &&
                      ((state_q == EMPTY) || last_xfer);
    assign FIFO_DEQ = deq;

    // Next-state, counter and hold-word update; CLR outranks everything.
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        hold_reg_d = hold_reg_q;
        if (CLR) begin
            state_d    = EMPTY;
            beat_cnt_d = '0;
        end else if (deq) begin
            state_d    = STREAM;
            beat_cnt_d = '0;
            hold_reg_d = FIFO_D_OUT;
        end else if (last_xfer) begin
            state_d    = EMPTY;
            beat_cnt_d = '0;
        end else if (beat_xfer) begin
            beat_cnt_d = beat_cnt_q + CNT_ONE;
        end
    end

    // Control state, beat counter and held word.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= EMPTY;
            beat_cnt_q <= '0;
            hold_reg_q <= '0;
            run_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            hold_reg_q <= hold_reg_d;
            run_q      <= 1'b1;
        end
    end

    fifo_width_down_sel #(
        .IN_WIDTH  (IN_WIDTH),
        .RATIO     (RATIO),
        .MSB_FIRST (MSB_FIRST),
        .BCW       (BCW)
    ) u_sel (
        .CLK      (CLK),
        .RST      (RST),
        .WORD     (hold_reg_d),
        .IDX      (beat_cnt_d),
        .OUT_DATA (OUT_DATA)
    );

    // The pop never fires on an empty FIFO.
    a_no_deq_when_empty: assert property (
        @(posedge CLK) disable iff (!RST) FIFO_DEQ |-> FIFO_EMPTY_N);

    // A stalled beat is held unchanged until it is taken (or flushed).
    a_stall_stable: assert property (
        @(posedge CLK) disable iff (!RST)
        (OUT_VALID && !OUT_READY && !CLR) |=>
            (OUT_VALID && $stable(OUT_DATA) && $stable(OUT_LAST)));

endmodule
